// File: rtl/x86_prefetch.sv
// x86 instruction prefetch queue: fetches code bytes at CS:IP into a FIFO.
// Optional X86_PREFETCH_BYPASS_EN forwards a byte to an empty queue's head.
module x86_prefetch #(
    parameter int DEPTH = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        bus_gnt,
    output logic        mem_req,
    output logic [19:0] mem_addr,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic        flush,
    input  logic [15:0] flush_cs,
    input  logic [15:0] flush_ip,
    output logic        q_valid,
    output logic [7:0]  q_data,
    output logic [15:0] q_ip,
    input  logic        q_pop,
    output logic [4:0]  q_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] FULL = 5'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   fcs;
    logic [15:0]   fip;
    logic [15:0]   hip;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [4:0]    count;
    logic [4:0]    count_nxt;
    logic          fill;
    logic          bypass;
    logic          pop;
    logic          wr_en;
    logic          rd_en;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign fill = (state == S_FETCH) && mem_ready && !flush;

`ifdef X86_PREFETCH_BYPASS_EN
    assign bypass = fill && (count == 5'd0);
`else
    assign bypass = 1'b0;
`endif

    assign q_valid = (count != 5'd0) || bypass;
    assign q_data  = bypass ? mem_rdata : mem_q[rd];
    assign q_ip    = hip;
    assign q_count = count;

    assign pop   = q_pop && q_valid && !flush;
    assign rd_en = pop && (count != 5'd0);
    // A bypassed byte popped the same cycle never lands in the buffer
    assign wr_en = fill && !(bypass && pop);

    assign count_nxt = count + 5'(wr_en) - 5'(rd_en);

    assign mem_req  = (state == S_FETCH);
    assign mem_addr = {fcs, 4'h0} + {4'h0, fip};

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (count < FULL && bus_gnt)
                    state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    if (!(count_nxt < FULL && bus_gnt))
                        state_nxt = S_IDLE;
                end else if (!bus_gnt) begin
                    state_nxt = S_IDLE;
                end
            end
            S_FLUSH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush)
            state_nxt = S_FLUSH;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fcs   <= 16'hFFFF;
            fip   <= 16'h0000;
            hip   <= 16'h0000;
            rd    <= '0;
            wr    <= '0;
            count <= 5'd0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else if (flush) begin
            fcs   <= flush_cs;
            fip   <= flush_ip;
            hip   <= flush_ip;
            rd    <= '0;
            wr    <= '0;
            count <= 5'd0;
        end else begin
            if (wr_en) begin
                mem_q[wr] <= mem_rdata;
                wr        <= ptr_inc(wr);
            end
            if (fill)
                fip <= fip + 16'd1;
            if (rd_en)
                rd <= ptr_inc(rd);
            if (pop)
                hip <= hip + 16'd1;
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_x86_prefetch.sv
// Bench for x86_prefetch: queue-based reference model, directed and random steps.
module tb_x86_prefetch;

    localparam int DEPTH = 6;
`ifdef X86_PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        bus_gnt;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_rdata;
    logic        flush;
    logic [15:0] flush_cs;
    logic [15:0] flush_ip;
    logic        q_valid;
    logic [7:0]  q_data;
    logic [15:0] q_ip;
    logic        q_pop;
    logic [4:0]  q_count;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mq[$];
    logic [15:0] m_fcs;
    logic [15:0] m_fip;
    logic [15:0] m_hip;
    bit          m_req;
    bit          m_flushing;
    bit          force_on;
    logic [7:0]  force_val;

    x86_prefetch #(.DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .bus_gnt(bus_gnt),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .flush(flush),
        .flush_cs(flush_cs),
        .flush_ip(flush_ip),
        .q_valid(q_valid),
        .q_data(q_data),
        .q_ip(q_ip),
        .q_pop(q_pop),
        .q_count(q_count)
    );

    initial clock = 1'b0;
    always #40 clock = ~clock;

    function automatic logic [7:0] byte_at(input logic [19:0] a);
        return a[7:0] ^ {a[19:16], a[11:8]} ^ 8'h5A;
    endfunction

    function automatic logic [19:0] m_addr();
        return {m_fcs, 4'h0} + {4'h0, m_fip};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fcs      = 16'hFFFF;
        m_fip      = 16'h0000;
        m_hip      = 16'h0000;
        m_req      = 1'b0;
        m_flushing = 1'b0;
    endtask

    // Called at a negedge: drive, check, advance model, return at next negedge
    task automatic cycle(input bit g, input bit r, input bit p, input bit f,
                         input logic [15:0] cs, input logic [15:0] ip);
        logic [19:0] a;
        logic [7:0]  cur;
        bit          got;
        bit          byp;
        bit          eat;
        int          old;
        a = m_addr();
        cur = force_on ? force_val : byte_at(a);
        bus_gnt   = g;
        mem_ready = r;
        q_pop     = p;
        flush     = f;
        flush_cs  = cs;
        flush_ip  = ip;
        mem_rdata = r ? cur : 8'($urandom);
        #1;
        got = m_req && r && !f;
        byp = BYP && got && (mq.size() == 0);
        chk("mem_req", 32'(mem_req), 32'(m_req));
        chk("mem_addr", 32'(mem_addr), 32'(a));
        chk("q_count", 32'(q_count), 32'(mq.size()));
        chk("q_ip", 32'(q_ip), 32'(m_hip));
        chk("q_valid", 32'(q_valid), 32'((mq.size() != 0) || byp));
        if (mq.size() != 0)
            chk("q_data", 32'(q_data), 32'(mq[0]));
        else if (byp)
            chk("q_data_byp", 32'(q_data), 32'(cur));
        if (f) begin
            mq.delete();
            m_fcs      = cs;
            m_fip      = ip;
            m_hip      = ip;
            m_req      = 1'b0;
            m_flushing = 1'b1;
        end else begin
            old = mq.size();
            eat = byp && p;
            if (p && (mq.size() != 0 || byp)) begin
                if (mq.size() != 0)
                    void'(mq.pop_front());
                m_hip = m_hip + 16'd1;
            end
            if (got && !eat)
                mq.push_back(cur);
            if (got)
                m_fip = m_fip + 16'd1;
            if (m_flushing) begin
                m_flushing = 1'b0;
                m_req      = 1'b0;
            end else if (!m_req) begin
                m_req = (old < DEPTH) && g;
            end else if (r) begin
                m_req = (mq.size() < DEPTH) && g;
            end else begin
                m_req = g;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run(input int n, input bit g, input bit r, input bit p);
        for (int i = 0; i < n; i++)
            cycle(g, r, p, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] rip;
        force_on  = 1'b0;
        force_val = 8'h00;
        reset_n   = 1'b0;
        bus_gnt   = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
        flush     = 1'b0;
        flush_cs  = 16'h0;
        flush_ip  = 16'h0;
        q_pop     = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'hFFFF0);
        chk("rst_q_valid", 32'(q_valid), 32'h0);
        chk("rst_q_data", 32'(q_data), 32'h0);
        chk("rst_q_ip", 32'(q_ip), 32'h0);
        chk("rst_q_count", 32'(q_count), 32'h0);
        reset_n = 1'b1;

        // Fill from reset vector
        run(8, 1'b1, 1'b1, 1'b0);
        chk("fill_count", 32'(q_count), 32'd6);
        chk("fill_req", 32'(mem_req), 32'h0);
        chk("fill_ip", 32'(q_ip), 32'h0);
        chk("fill_head", 32'(q_data), 32'(byte_at(20'hFFFF0)));

        // Pop three from full, then refill
        run(3, 1'b1, 1'b1, 1'b1);
        chk("pop_ip", 32'(q_ip), 32'h3);
        chk("pop_head", 32'(q_data), 32'(byte_at(20'hFFFF3)));
        run(6, 1'b1, 1'b1, 1'b0);
        chk("refill_count", 32'(q_count), 32'd6);

        // Flush while a byte is returning
        run(2, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0010);
        chk("flush_count", 32'(q_count), 32'd0);
        chk("flush_ip", 32'(q_ip), 32'h0010);
        chk("flush_addr", 32'(mem_addr), 32'h12350);
        run(4, 1'b1, 1'b1, 1'b0);

        // IP wrap without carrying into CS
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h1000, 16'hFFFF);
        run(2, 1'b1, 1'b1, 1'b0);
        chk("wrap_req", 32'(mem_req), 32'h1);
        chk("wrap_addr0", 32'(mem_addr), 32'h1FFFF);
        run(1, 1'b1, 1'b1, 1'b0);
        chk("wrap_addr1", 32'(mem_addr), 32'h10000);
        run(1, 1'b1, 1'b1, 1'b0);
        chk("wrap_ip", 32'(q_ip), 32'hFFFF);

        // Grant withdrawn mid-fetch with no data, then regrant
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0800, 16'h0020);
        run(3, 1'b1, 1'b0, 1'b0);
        chk("gnt_req_hi", 32'(mem_req), 32'h1);
        run(1, 1'b1, 1'b1, 1'b0);
        run(1, 1'b0, 1'b0, 1'b0);
        chk("gnt_req_lo", 32'(mem_req), 32'h0);
        chk("gnt_count", 32'(q_count), 32'd1);
        run(1, 1'b1, 1'b0, 1'b0);
        chk("regnt_addr", 32'(mem_addr), 32'h08021);
        run(2, 1'b1, 1'b1, 1'b0);

`ifdef X86_PREFETCH_BYPASS_EN
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h2000, 16'h0100);
        run(2, 1'b1, 1'b0, 1'b0);
        force_on  = 1'b1;
        force_val = 8'h90;
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0);
        force_on  = 1'b0;
        chk("byp_count", 32'(q_count), 32'd0);
        chk("byp_ip", 32'(q_ip), 32'h0101);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rip = ($urandom_range(0, 3) == 0) ?
                  16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3,
                  16'($urandom), rip);
        end

        // Asynchronous reset in the middle of a fetch
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0400, 16'h0000);
        run(3, 1'b1, 1'b0, 1'b0);
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        #5;
        reset_n = 1'b0;
        #1;
        chk("async_req", 32'(mem_req), 32'h0);
        chk("async_addr", 32'(mem_addr), 32'hFFFF0);
        chk("async_count", 32'(q_count), 32'h0);
        chk("async_ip", 32'(q_ip), 32'h0);
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        run(10, 1'b1, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
